multibank_framebuffer: RTL and testbench



---
 rtl/multibank_framebuffer.sv | 159 +++++++++++++++
 tb/tb_multibank_framebuffer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multibank_framebuffer.sv
// multibank_framebuffer: byte-write / wide-read framebuffer for the LED panel path.
// Each (bank, segment, byte) combination is its own byte-wide lane memory so a
// single read returns one pixel from every scan segment. With FRAMES=2 the two
// banks are swapped only at a reader frame boundary to avoid tearing.
//
// Swap FSM:
//   state   | meaning
//   IDLE    | no swap outstanding
//   PENDING | swap requested, waiting for frame_sync to commit
module multibank_framebuffer #(
    parameter int PIXEL_WIDTH     = 64,
    parameter int PIXEL_HEIGHT    = 32,
    parameter int BYTES_PER_PIXEL = 2,
    parameter int SEGMENTS        = 2,
    parameter int FRAMES          = 2,
    localparam int SEG_W  = (SEGMENTS > 1) ? $clog2(SEGMENTS) : 1,
    localparam int PIX_W  = $clog2(PIXEL_WIDTH * PIXEL_HEIGHT / SEGMENTS),
    localparam int BYTE_W = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1,
    localparam int ADDR_W = SEG_W + PIX_W + BYTE_W,
    localparam int DATA_W = SEGMENTS * BYTES_PER_PIXEL * 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    input  logic [PIX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              swap_req,
    input  logic              frame_sync,
    output logic              front_sel,
    output logic              swap_pending,
    output logic              swap_done,
    output logic              wr_err
);

    localparam int LANES = SEGMENTS * BYTES_PER_PIXEL;
    localparam int DEPTH = 1 << PIX_W;

    typedef enum logic {IDLE, PENDING} swap_state_t;

    swap_state_t state, state_nxt;
    logic        commit;

    logic [SEG_W-1:0]  wr_seg;
    logic [PIX_W-1:0]  wr_pix;
    logic [BYTE_W-1:0] wr_byte;
    logic [31:0]       wr_lane;
    logic              wr_legal;
    logic              wr_bank;
    logic              rd_bank;

    logic [7:0] lane_rd [FRAMES][LANES];

    assign wr_seg   = wr_addr[ADDR_W-1 -: SEG_W];
    assign wr_pix   = wr_addr[BYTE_W +: PIX_W];
    assign wr_byte  = wr_addr[BYTE_W-1:0];
    assign wr_lane  = 32'(wr_seg) * BYTES_PER_PIXEL + 32'(wr_byte);
    assign wr_legal = (32'(wr_seg) < SEGMENTS) && (32'(wr_byte) < BYTES_PER_PIXEL);

    // Writes always land in the back bank; reads always come from the front bank.
    assign wr_bank = (FRAMES == 2) ? ~front_sel : 1'b0;
    assign rd_bank = (FRAMES == 2) ? front_sel : 1'b0;

    for (genvar f = 0; f < FRAMES; f++) begin : g_bank
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic       we;

            assign we = wr_en && wr_legal && (wr_bank == 1'(f)) && (wr_lane == 32'(l));

            // Lane write; no reset so frame contents survive a controller reset.
            always_ff @(posedge clk) begin
                if (we) begin
                    mem[wr_pix] <= wr_data;
                end
            end

            assign lane_rd[f][l] = mem[rd_addr];
        end
    end

    // Registered wide read; combinational lane read gives read-before-write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                for (int l = 0; l < LANES; l++) begin
                    rd_data[l*8 +: 8] <= lane_rd[rd_bank][l];
                end
            end
        end
    end

    // Sticky illegal-address flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_err <= 1'b0;
        end else if (wr_en && !wr_legal) begin
            wr_err <= 1'b1;
        end
    end

    // Swap FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Swap FSM next state; a single-bank build never leaves IDLE.
    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        if (FRAMES == 2) begin
            case (state)
                IDLE: begin
                    if (swap_req) begin
                        if (frame_sync) begin
                            commit = 1'b1;
                        end else begin
                            state_nxt = PENDING;
                        end
                    end
                end
                PENDING: begin
                    if (frame_sync) begin
                        commit    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign swap_pending = (state == PENDING);

    // Bank toggle and commit pulse, both taking effect on the commit edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            front_sel <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            swap_done <= commit;
            if (commit) begin
                front_sel <= ~front_sel;
            end
        end
    end

endmodule

// File: tb/tb_multibank_framebuffer.sv
// Directed bench: double-buffered default instance plus a single-bank,
// three-byte-per-pixel instance for read-before-write and illegal-address cases.
module tb_multibank_framebuffer;

    logic clk;
    int   total = 0;
    int   bad   = 0;

    // Default instance: ADDR_W=12, PIX_W=10, DATA_W=32
    logic        rst0, wr_en0, rd_en0, swap_req0, frame_sync0;
    logic [11:0] wr_addr0;
    logic [7:0]  wr_data0;
    logic [9:0]  rd_addr0;
    logic [31:0] rd_data0;
    logic        rd_valid0, front_sel0, swap_pending0, swap_done0, wr_err0;

    // FRAMES=1, BYTES_PER_PIXEL=3: ADDR_W=13, PIX_W=10, DATA_W=48
    logic        rst1, wr_en1, rd_en1, swap_req1, frame_sync1;
    logic [12:0] wr_addr1;
    logic [7:0]  wr_data1;
    logic [9:0]  rd_addr1;
    logic [47:0] rd_data1;
    logic        rd_valid1, front_sel1, swap_pending1, swap_done1, wr_err1;

    multibank_framebuffer dut0 (
        .clk(clk), .reset(rst0),
        .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
        .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0), .rd_valid(rd_valid0),
        .swap_req(swap_req0), .frame_sync(frame_sync0),
        .front_sel(front_sel0), .swap_pending(swap_pending0),
        .swap_done(swap_done0), .wr_err(wr_err0)
    );

    multibank_framebuffer #(.BYTES_PER_PIXEL(3), .FRAMES(1)) dut1 (
        .clk(clk), .reset(rst1),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1), .rd_valid(rd_valid1),
        .swap_req(swap_req1), .frame_sync(frame_sync1),
        .front_sel(front_sel1), .swap_pending(swap_pending1),
        .swap_done(swap_done1), .wr_err(wr_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr0(input logic [11:0] a, input logic [7:0] d);
        wr_en0 = 1'b1; wr_addr0 = a; wr_data0 = d;
        tick();
        wr_en0 = 1'b0;
    endtask

    task automatic wr1(input logic [12:0] a, input logic [7:0] d);
        wr_en1 = 1'b1; wr_addr1 = a; wr_data1 = d;
        tick();
        wr_en1 = 1'b0;
    endtask

    task automatic rd0(input logic [9:0] a);
        rd_en0 = 1'b1; rd_addr0 = a;
        tick();
        rd_en0 = 1'b0;
    endtask

    task automatic swap_sync0();
        swap_req0 = 1'b1; frame_sync0 = 1'b1;
        tick();
        swap_req0 = 1'b0; frame_sync0 = 1'b0;
    endtask

    initial begin
        rst0 = 1'b1; wr_en0 = 0; wr_addr0 = '0; wr_data0 = '0; rd_en0 = 0; rd_addr0 = '0;
        swap_req0 = 0; frame_sync0 = 0;
        rst1 = 1'b1; wr_en1 = 0; wr_addr1 = '0; wr_data1 = '0; rd_en1 = 0; rd_addr1 = '0;
        swap_req1 = 0; frame_sync1 = 0;
        tick();
        tick();

        chk("rst_rd_data", 64'(rd_data0), 64'h0);
        chk("rst_rd_valid", 64'(rd_valid0), 64'h0);
        chk("rst_front_sel", 64'(front_sel0), 64'h0);
        chk("rst_swap_pending", 64'(swap_pending0), 64'h0);
        chk("rst_swap_done", 64'(swap_done0), 64'h0);
        chk("rst_wr_err", 64'(wr_err0), 64'h0);
        rst0 = 1'b0;
        rst1 = 1'b0;
        tick();

        // Fill pixel 0x3FF of both segments in back bank 1, then swap it to the front.
        wr0(12'hFFF, 8'h41);
        wr0(12'hFFE, 8'h42);
        wr0(12'h7FF, 8'h5A);
        wr0(12'h7FE, 8'h59);
        swap_sync0();
        chk("imm_swap_front", 64'(front_sel0), 64'h1);
        chk("imm_swap_done", 64'(swap_done0), 64'h1);
        chk("imm_swap_pending", 64'(swap_pending0), 64'h0);
        rd0(10'h3FF);
        chk("rd1_data", 64'(rd_data0), 64'h4142_5A59);
        chk("rd1_valid", 64'(rd_valid0), 64'h1);
        chk("done_one_cycle", 64'(swap_done0), 64'h0);
        tick();
        chk("rd1_valid_drop", 64'(rd_valid0), 64'h0);
        chk("rd1_data_hold", 64'(rd_data0), 64'h4142_5A59);

        // Back bank 0 writes must not disturb what the reader sees.
        wr0(12'hFFF, 8'h43);
        wr0(12'hFFE, 8'h42);
        wr0(12'h7FF, 8'h11);
        wr0(12'h7FE, 8'h10);
        rd0(10'h3FF);
        chk("rd_front_untouched", 64'(rd_data0), 64'h4142_5A59);
        swap_sync0();
        chk("swap2_front", 64'(front_sel0), 64'h0);
        rd0(10'h3FF);
        chk("rd_bank0", 64'(rd_data0), 64'h4342_1110);

        // Deferred swap: hold the request pending across many cycles.
        swap_req0 = 1'b1;
        tick();
        swap_req0 = 1'b0;
        chk("pend_rise", 64'(swap_pending0), 64'h1);
        repeat (99) tick();
        chk("pend_hold", 64'(swap_pending0), 64'h1);
        chk("pend_front_hold", 64'(front_sel0), 64'h0);
        chk("pend_no_done", 64'(swap_done0), 64'h0);
        swap_req0 = 1'b1;
        tick();
        swap_req0 = 1'b0;
        chk("pend_second_req", 64'(swap_pending0), 64'h1);
        chk("pend_second_front", 64'(front_sel0), 64'h0);
        // Commit edge with a read: the read must still use the old front bank (0).
        frame_sync0 = 1'b1; rd_en0 = 1'b1; rd_addr0 = 10'h3FF;
        tick();
        frame_sync0 = 1'b0; rd_en0 = 1'b0;
        chk("commit_front", 64'(front_sel0), 64'h1);
        chk("commit_done", 64'(swap_done0), 64'h1);
        chk("commit_pend_clear", 64'(swap_pending0), 64'h0);
        chk("commit_rd_old_bank", 64'(rd_data0), 64'h4342_1110);
        tick();
        chk("commit_done_pulse", 64'(swap_done0), 64'h0);
        chk("commit_front_stay", 64'(front_sel0), 64'h1);

        // Back-to-back reads from bank 1.
        rd_en0 = 1'b1; rd_addr0 = 10'h3FF;
        tick();
        chk("b2b_valid0", 64'(rd_valid0), 64'h1);
        chk("b2b_data0", 64'(rd_data0), 64'h4142_5A59);
        tick();
        rd_en0 = 1'b0;
        chk("b2b_valid1", 64'(rd_valid0), 64'h1);
        tick();
        chk("b2b_valid_end", 64'(rd_valid0), 64'h0);

        // Asynchronous reset while a swap is pending and read data is valid.
        swap_req0 = 1'b1; rd_en0 = 1'b1; rd_addr0 = 10'h3FF;
        tick();
        swap_req0 = 1'b0; rd_en0 = 1'b0;
        chk("pre_rst_pending", 64'(swap_pending0), 64'h1);
        chk("pre_rst_valid", 64'(rd_valid0), 64'h1);
        #2;
        rst0 = 1'b1;
        #1;
        chk("arst_rd_data", 64'(rd_data0), 64'h0);
        chk("arst_rd_valid", 64'(rd_valid0), 64'h0);
        chk("arst_front", 64'(front_sel0), 64'h0);
        chk("arst_pending", 64'(swap_pending0), 64'h0);
        chk("arst_done", 64'(swap_done0), 64'h0);
        tick();
        rst0 = 1'b0;
        frame_sync0 = 1'b1;
        tick();
        frame_sync0 = 1'b0;
        chk("post_rst_no_done", 64'(swap_done0), 64'h0);
        chk("post_rst_front", 64'(front_sel0), 64'h0);
        rd0(10'h3FF);
        chk("post_rst_mem_kept", 64'(rd_data0), 64'h4342_1110);
        chk("dut0_no_wr_err", 64'(wr_err0), 64'h0);

        // Single bank: same-cycle read and write of one address reads old data.
        wr1(13'h0000, 8'h11);
        wr1(13'h1000, 8'h33);
        wr_en1 = 1'b1; wr_addr1 = 13'h0000; wr_data1 = 8'h22;
        rd_en1 = 1'b1; rd_addr1 = 10'h000;
        tick();
        wr_en1 = 1'b0; rd_en1 = 1'b0;
        chk("f1_rbw_old", 64'(rd_data1[7:0]), 64'h11);
        chk("f1_rbw_valid", 64'(rd_valid1), 64'h1);
        rd_en1 = 1'b1;
        tick();
        rd_en1 = 1'b0;
        chk("f1_new_data", 64'(rd_data1[7:0]), 64'h22);
        chk("f1_seg1_lane", 64'(rd_data1[31:24]), 64'h33);
        swap_req1 = 1'b1; frame_sync1 = 1'b1;
        tick();
        swap_req1 = 1'b0; frame_sync1 = 1'b0;
        chk("f1_front", 64'(front_sel1), 64'h0);
        chk("f1_done", 64'(swap_done1), 64'h0);
        swap_req1 = 1'b1;
        tick();
        swap_req1 = 1'b0;
        tick();
        chk("f1_pending", 64'(swap_pending1), 64'h0);
        chk("f1_rd_hold", 64'(rd_data1[7:0]), 64'h22);

        // Illegal byte index 3 must be dropped and flag wr_err.
        chk("f1_err_clear", 64'(wr_err1), 64'h0);
        wr1(13'h0003, 8'hEE);
        chk("f1_err_set", 64'(wr_err1), 64'h1);
        wr1(13'h1003, 8'hDD);
        wr1(13'h0001, 8'h44);
        chk("f1_err_sticky", 64'(wr_err1), 64'h1);
        rd_en1 = 1'b1; rd_addr1 = 10'h000;
        tick();
        rd_en1 = 1'b0;
        chk("f1_lanes_unchanged", 64'(rd_data1[31:24]), 64'h33);
        chk("f1_lane0_unchanged", 64'(rd_data1[7:0]), 64'h22);
        chk("f1_legal_byte1", 64'(rd_data1[15:8]), 64'h44);
        rst1 = 1'b1;
        #1;
        chk("f1_err_reset", 64'(wr_err1), 64'h0);
        tick();
        rst1 = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
